// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard / stall / flush sequencer for a 5-stage LEGv8 pipeline
//            (IF/ID/EX/MEM/WB). Decodes the instruction sitting in ID, keeps a
//            private shadow of the EX and MEM destination registers, and
//            drives PC / IF-ID hold, ID/EX bubble insertion and IF-ID flush.
//            Operand forwarding lives elsewhere; this block only covers the
//            load-use case forwarding cannot resolve, plus taken-branch flush.
//
// Parameters
//   LD_STALL      load-use bubble cycles per hazard (legal 1..3)
//
// Optional feature
//   `HAZARD_PERF_EN  enables saturating 32-bit stall / flush event counters.
//                    When undefined, stall_cnt / flush_cnt read 0 and no
//                    counter flops exist.
//
// Ports
//   clk          in   1   core clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   id_instr     in  32   instruction in ID
//   id_valid     in   1   ID holds a real instruction
//   br_taken_ex  in   1   branch in EX resolved taken this cycle
//   pc_hold      out  1   PC keeps its value
//   ifid_hold    out  1   IF/ID keeps its value
//   idex_bubble  out  1   ID/EX loads a NOP
//   ifid_flush   out  1   IF/ID loads a NOP
//   stall_cnt    out 32   cycles with pc_hold=1 (perf build only)
//   flush_cnt    out 32   cycles with br_taken_ex=1 (perf build only)
//
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int LD_STALL = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        br_taken_ex,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } state_t;

    // Counter holds the number of stall cycles still to come after the
    // detection cycle, so it is loaded with LD_STALL-1.
    localparam logic [1:0] c_CNT_INIT = 2'(LD_STALL - 1);
    localparam logic [4:0] c_XZR      = 5'd31;
    localparam logic       c_MULTI    = (LD_STALL >= 2) ? 1'b1 : 1'b0;

    // ------------------------------------------------------------------
    // ID-stage decode
    // ------------------------------------------------------------------
    logic [10:0] w_opc;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic [4:0]  w_rd;
    logic        w_use_rn;
    logic        w_use_rm;
    logic        w_use_rt;
    logic        w_wr;
    logic        w_ld;
    logic [5:0]  w_unused_shamt;

    assign w_opc          = id_instr[31:21];
    assign w_rm           = id_instr[20:16];
    assign w_rn           = id_instr[9:5];
    assign w_rd           = id_instr[4:0];
    assign w_unused_shamt = id_instr[15:10];

    always_comb begin
        w_use_rn = 1'b0;
        w_use_rm = 1'b0;
        w_use_rt = 1'b0;
        w_wr     = 1'b0;
        w_ld     = 1'b0;
        casez (w_opc)
            11'b10101011000,             // ADDS
            11'b11101011000,             // SUBS
            11'b10001010000,             // AND
            11'b11001010000: begin       // EOR
                w_use_rn = 1'b1;
                w_use_rm = 1'b1;
                w_wr     = 1'b1;
            end
            11'b1001000100?,             // ADDI (10-bit opcode)
            11'b11010011010: begin       // LSR
                w_use_rn = 1'b1;
                w_wr     = 1'b1;
            end
            11'b11111000010: begin       // LDUR
                w_use_rn = 1'b1;
                w_wr     = 1'b1;
                w_ld     = 1'b1;
            end
            11'b11111000000: begin       // STUR reads the data register Rt
                w_use_rn = 1'b1;
                w_use_rt = 1'b1;
            end
            11'b10110100???: begin       // CBZ (8-bit opcode)
                w_use_rt = 1'b1;
            end
            default: begin               // B, B.cond and unknown: no regs
                w_use_rn = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow of EX / MEM destinations
    // ------------------------------------------------------------------
    logic       ex_v_q;
    logic [4:0] ex_rd_q;
    logic       ex_ld_q;
    logic       mem_v_q;
    logic [4:0] mem_rd_q;
    logic       mem_ld_q;
    logic       ex_v_d;

    state_t     state_q;
    logic [1:0] cnt_q;

    logic w_ex_match;
    logic w_mem_match;
    logic w_ex_hazard;
    logic w_mem_hazard;
    logic w_in_ldstall;
    logic w_hazard;
    logic w_stall;
    logic w_flush;

    assign w_ex_match  = (w_use_rn && (w_rn == ex_rd_q))
                       || (w_use_rm && (w_rm == ex_rd_q))
                       || (w_use_rt && (w_rd == ex_rd_q));
    assign w_mem_match = (w_use_rn && (w_rn == mem_rd_q))
                       || (w_use_rm && (w_rm == mem_rd_q))
                       || (w_use_rt && (w_rd == mem_rd_q));

    // X31 is the zero register: it never carries a dependency.
    assign w_ex_hazard  = ex_v_q && ex_ld_q && (ex_rd_q != c_XZR) && w_ex_match;
    assign w_mem_hazard = mem_v_q && mem_ld_q && (mem_rd_q != c_XZR) && w_mem_match;
    assign w_in_ldstall = (state_q == LDSTALL);

    // With multi-cycle memory the load has already moved to MEM while the
    // counter runs; its dependency is still live for that window.
    assign w_hazard = id_valid
                   && (w_ex_hazard || (c_MULTI && w_in_ldstall && w_mem_hazard));

    // A taken branch makes the ID instruction wrong-path, so it overrides any
    // stall. The first stall cycle must be same-cycle as detection, hence the
    // hold outputs are combinational from the hazard term.
    assign w_stall = !br_taken_ex && (w_hazard || w_in_ldstall);
    assign w_flush = br_taken_ex && reset_n;

    assign pc_hold     = w_stall;
    assign ifid_hold   = w_stall;
    assign idex_bubble = w_stall || w_flush;
    assign ifid_flush  = w_flush;

    // ------------------------------------------------------------------
    // Stall sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else if (br_taken_ex) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_stall) begin
                        cnt_q <= c_CNT_INIT;
                        if (c_MULTI) begin
                            state_q <= LDSTALL;
                        end
                    end
                end
                LDSTALL: begin
                    cnt_q <= cnt_q - 2'd1;
                    // Leave once this cycle was the last remaining bubble.
                    if (cnt_q <= 2'd1) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow pipe advance
    // ------------------------------------------------------------------
    // Only register-writing instructions with a real destination are
    // tracked; anything bubbled or flushed enters EX as invalid.
    assign ex_v_d = id_valid && !idex_bubble && w_wr && (w_rd != c_XZR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= 5'd0;
            ex_ld_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= 5'd0;
            mem_ld_q <= 1'b0;
        end else begin
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_ld_q <= ex_ld_q;
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= w_rd;
            ex_ld_q  <= w_ld;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (pc_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (br_taken_ex && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed bench for pipeline_hazard_ctrl. Two instances share the
//            stimulus (LD_STALL=1 and LD_STALL=3). A register-level model of
//            the pipeline rules predicts every output each cycle; a few
//            literal expectations pin the model on the key scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int K_NOP  = 0;
    localparam int K_ADDS = 1;
    localparam int K_SUBS = 2;
    localparam int K_AND  = 3;
    localparam int K_EOR  = 4;
    localparam int K_ADDI = 5;
    localparam int K_LSR  = 6;
    localparam int K_LDUR = 7;
    localparam int K_STUR = 8;
    localparam int K_CBZ  = 9;
    localparam int K_B    = 10;
    localparam int K_BLT  = 11;

    typedef struct {
        bit v;
        int kind;
        int rd;
        int rn;
        int rm;
        bit br;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic        id_valid = 1'b0;
    logic        br_taken_ex = 1'b0;
    logic [1:0]  ph;
    logic [1:0]  ih;
    logic [1:0]  bb;
    logic [1:0]  fl;
    logic [31:0] sc [2];
    logic [31:0] fc [2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LD_STALL(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
        .br_taken_ex(br_taken_ex), .pc_hold(ph[0]), .ifid_hold(ih[0]),
        .idex_bubble(bb[0]), .ifid_flush(fl[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
    );

    pipeline_hazard_ctrl #(.LD_STALL(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
        .br_taken_ex(br_taken_ex), .pc_hold(ph[1]), .ifid_hold(ih[1]),
        .idex_bubble(bb[1]), .ifid_flush(fl[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
    );

    int n_chk = 0;
    int n_fail = 0;
    vec_t cur;

    function automatic int ldv(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (LD_STALL=%0d) at %0t: got %0d expected %0d", nm, ldv(d), $time, act, exp);
        end
    endtask

    // ---------------- instruction construction ----------------
    function automatic vec_t mk(input int k, input int rd, input int rn, input int rm);
        vec_t x;
        x.v = 1'b1; x.kind = k; x.rd = rd; x.rn = rn; x.rm = rm; x.br = 1'b0;
        return x;
    endfunction

    function automatic vec_t with_br(input vec_t x);
        vec_t y;
        y = x; y.br = 1'b1;
        return y;
    endfunction

    function automatic vec_t inval(input vec_t x);
        vec_t y;
        y = x; y.v = 1'b0;
        return y;
    endfunction

    // Unused fields are filled with register numbers so that a decoder
    // looking at the wrong field would see a false dependency.
    function automatic logic [31:0] enc(input vec_t x);
        logic [4:0] d, n, m;
        d = 5'(x.rd); n = 5'(x.rn); m = 5'(x.rm);
        case (x.kind)
            K_ADDS: enc = {11'h558, m, 6'h2A, n, d};
            K_SUBS: enc = {11'h758, m, 6'h2A, n, d};
            K_AND:  enc = {11'h450, m, 6'h00, n, d};
            K_EOR:  enc = {11'h650, m, 6'h00, n, d};
            K_ADDI: enc = {10'h244, 1'b1, m, 6'h15, n, d};
            K_LSR:  enc = {11'h69A, m, 6'd3, n, d};
            K_LDUR: enc = {11'h7C2, m, 4'h0, 2'b00, n, d};
            K_STUR: enc = {11'h7C0, m, 4'h0, 2'b00, n, d};
            K_CBZ:  enc = {8'hB4, 3'b000, m, 6'h00, n, d};
            K_B:    enc = {6'b000101, 6'h00, m, 5'h00, n, d};
            K_BLT:  enc = {8'h54, 3'b000, m, 6'h00, n, 5'hB};
            default: enc = {11'h000, m, 6'h00, n, d};
        endcase
    endfunction

    // ---------------- architectural model ----------------
    function automatic bit reads(input vec_t x, input int r);
        case (x.kind)
            K_ADDS, K_SUBS, K_AND, K_EOR: return (x.rn == r) || (x.rm == r);
            K_ADDI, K_LSR, K_LDUR:        return (x.rn == r);
            K_STUR:                       return (x.rn == r) || (x.rd == r);
            K_CBZ:                        return (x.rd == r);
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic int dest(input vec_t x);
        case (x.kind)
            K_ADDS, K_SUBS, K_AND, K_EOR, K_ADDI, K_LSR, K_LDUR:
                return (x.rd == 31) ? -1 : x.rd;
            default: return -1;
        endcase
    endfunction

    int m_ex_dst [2];
    bit m_ex_ld  [2];
    int m_left   [2];
    int m_sc     [2];
    int m_fc;
    bit e_hold   [2];
    bit e_bub    [2];
    int e_nl     [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ex_dst[d] = -1; m_ex_ld[d] = 1'b0; m_left[d] = 0; m_sc[d] = 0;
            e_hold[d] = 1'b0; e_bub[d] = 1'b0; e_nl[d] = 0;
        end
        m_fc = 0;
    end

    // Compare process: mid-cycle, inputs and state are stable.
    always @(negedge clk) begin : p_compare
        bit eh, ebub, efl;
        int nl;
        for (int d = 0; d < 2; d++) begin
            eh = 1'b0; ebub = 1'b0; efl = 1'b0; nl = m_left[d];
            if (!reset_n) begin
                nl = 0;
            end else if (cur.br) begin
                efl = 1'b1; ebub = 1'b1; nl = 0;
            end else if (m_left[d] > 0) begin
                eh = 1'b1; ebub = 1'b1; nl = m_left[d] - 1;
            end else if (cur.v && m_ex_ld[d] && (m_ex_dst[d] >= 0) && reads(cur, m_ex_dst[d])) begin
                eh = 1'b1; ebub = 1'b1; nl = ldv(d) - 1;
            end
            chk("pc_hold", d, ph[d], eh);
            chk("ifid_hold", d, ih[d], eh);
            chk("idex_bubble", d, bb[d], ebub);
            chk("ifid_flush", d, fl[d], efl);
`ifdef HAZARD_PERF_EN
            chk("stall_cnt", d, sc[d], m_sc[d]);
            chk("flush_cnt", d, fc[d], m_fc);
`else
            chk("stall_cnt", d, sc[d], 0);
            chk("flush_cnt", d, fc[d], 0);
`endif
            e_hold[d] <= eh;
            e_bub[d]  <= ebub;
            e_nl[d]   <= nl;
        end
    end

    // Model state advance at the clock edge.
    always @(posedge clk or negedge reset_n) begin : p_model
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_ex_dst[d] <= -1; m_ex_ld[d] <= 1'b0; m_left[d] <= 0; m_sc[d] <= 0;
            end
            m_fc <= 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_left[d] <= e_nl[d];
                if (cur.v && !e_bub[d]) begin
                    m_ex_dst[d] <= dest(cur);
                    m_ex_ld[d]  <= (cur.kind == K_LDUR);
                end else begin
                    m_ex_dst[d] <= -1;
                    m_ex_ld[d]  <= 1'b0;
                end
                if (e_hold[d]) m_sc[d] <= m_sc[d] + 1;
            end
            if (cur.br) m_fc <= m_fc + 1;
        end
    end

    // ---------------- stimulus ----------------
    int seg [2];
    bit s_ph [2];
    bit s_bb [2];
    bit s_fl [2];

    task automatic drive(input vec_t x);
        cur = x;
        id_instr = enc(x);
        id_valid = x.v;
        br_taken_ex = x.br;
    endtask

    task automatic sample_mid();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            seg[d] += int'(ph[d]);
            s_ph[d] = ph[d]; s_bb[d] = bb[d]; s_fl[d] = fl[d];
        end
    endtask

    task automatic cyc(input vec_t x);
        drive(x);
        sample_mid();
        @(posedge clk);
        #1;
    endtask

    task automatic seg_clear();
        seg[0] = 0; seg[1] = 0;
    endtask

    // LDUR Xrt then a consumer held in ID for three cycles, then an idle slot.
    task automatic ld_use(input string nm, input int rt, input vec_t cons, input bit hz);
        seg_clear();
        cyc(mk(K_LDUR, rt, 12, 0));
        repeat (3) cyc(cons);
        cyc(inval(mk(K_NOP, 0, 0, 0)));
        chk(nm, 0, seg[0], hz ? 1 : 0);
        chk(nm, 1, seg[1], hz ? 3 : 0);
    endtask

    initial begin : p_stim
        vec_t adds;
        int exp_perf;
        adds = mk(K_ADDS, 3, 1, 4);
        cur = inval(mk(K_NOP, 0, 0, 0));
        seg_clear();

        // Reset with a branch and a would-be hazard presented: all outputs low.
        reset_n = 1'b0;
        cyc(with_br(adds));
        cyc(with_br(adds));
        chk("rst_flush_lit", 0, s_fl[0], 0);
        chk("rst_bubble_lit", 1, s_bb[1], 0);
        reset_n = 1'b1;

        // First cycle after release cannot stall.
        seg_clear();
        cyc(adds);
        chk("post_rst_lit", 1, seg[1], 0);

        // LDUR X1 ; ADDS X3,X1,X4
        seg_clear();
        cyc(mk(K_LDUR, 1, 2, 0));
        repeat (4) cyc(adds);
        chk("ldur_adds_lit", 0, seg[0], 1);
        chk("ldur_adds_lit", 1, seg[1], 3);

        // LDUR X31 ; ADDS X3,X31,X4 -> zero register never stalls
        seg_clear();
        cyc(mk(K_LDUR, 31, 2, 0));
        repeat (3) cyc(mk(K_ADDS, 3, 31, 4));
        chk("xzr_lit", 0, seg[0], 0);
        chk("xzr_lit", 1, seg[1], 0);

        // STUR X1 ; CBZ X1 -> store writes nothing
        seg_clear();
        cyc(mk(K_STUR, 1, 2, 0));
        repeat (3) cyc(mk(K_CBZ, 1, 0, 0));
        chk("stur_cbz_lit", 0, seg[0], 0);
        chk("stur_cbz_lit", 1, seg[1], 0);

        // Decode sweep against a load of X7
        ld_use("subs_rm",   7, mk(K_SUBS, 9, 8, 7), 1'b1);
        ld_use("and_rn",    7, mk(K_AND,  9, 7, 8), 1'b1);
        ld_use("eor_none",  7, mk(K_EOR,  9, 8, 6), 1'b0);
        ld_use("addi_rn",   7, mk(K_ADDI, 9, 7, 0), 1'b1);
        ld_use("addi_imm",  7, mk(K_ADDI, 9, 8, 7), 1'b0);
        ld_use("lsr_rn",    7, mk(K_LSR,  9, 7, 0), 1'b1);
        ld_use("lsr_rmfld", 7, mk(K_LSR,  9, 8, 7), 1'b0);
        ld_use("stur_rt",   7, mk(K_STUR, 7, 8, 0), 1'b1);
        ld_use("cbz_rt",    7, mk(K_CBZ,  7, 0, 0), 1'b1);
        ld_use("cbz_other", 7, mk(K_CBZ,  8, 7, 7), 1'b0);
        ld_use("b_none",    7, mk(K_B,    7, 7, 7), 1'b0);
        ld_use("blt_none",  7, mk(K_BLT,  7, 7, 7), 1'b0);
        ld_use("unk_none",  7, mk(K_NOP,  7, 7, 7), 1'b0);
        ld_use("ld_chain",  7, mk(K_LDUR, 9, 7, 0), 1'b1);
        ld_use("invalid",   7, inval(mk(K_ADDS, 9, 7, 8)), 1'b0);

        // id_valid drops during the stall: the stall still completes.
        seg_clear();
        cyc(mk(K_LDUR, 1, 2, 0));
        cyc(adds);
        repeat (3) cyc(inval(adds));
        chk("idv0_run_lit", 0, seg[0], 1);
        chk("idv0_run_lit", 1, seg[1], 3);

        // LDUR X5 in EX, CBZ X5 in ID with a taken branch: flush, no stall.
        seg_clear();
        cyc(mk(K_LDUR, 5, 2, 0));
        cyc(with_br(mk(K_CBZ, 5, 0, 0)));
        chk("flush_lit", 0, s_fl[0], 1);
        chk("flush_bub_lit", 0, s_bb[0], 1);
        chk("flush_hold_lit", 1, s_ph[1], 0);
        repeat (2) cyc(mk(K_CBZ, 5, 0, 0));
        chk("flush_nostall_lit", 0, seg[0], 0);
        chk("flush_nostall_lit", 1, seg[1], 0);

        // Reset pulled mid-LDSTALL, with a branch and hazard present.
        cyc(mk(K_LDUR, 1, 2, 0));
        cyc(adds);
        cyc(adds);
        drive(with_br(adds));
        reset_n = 1'b0;
        sample_mid();
        chk("rst_mid_hold_lit", 1, s_ph[1], 0);
        chk("rst_mid_bub_lit", 1, s_bb[1], 0);
        chk("rst_mid_flush_lit", 1, s_fl[1], 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seg_clear();
        cyc(adds);
        chk("rst_release_lit", 1, seg[1], 0);

        // Branch during LDSTALL cycle 2 of 3 aborts the stall.
        seg_clear();
        cyc(mk(K_LDUR, 1, 2, 0));
        cyc(adds);
        cyc(with_br(adds));
        cyc(adds);
        cyc(adds);
        chk("abort_lit", 1, seg[1], 1);
`ifdef HAZARD_PERF_EN
        exp_perf = 1;
`else
        exp_perf = 0;
`endif
        chk("abort_stall_cnt_lit", 1, sc[1], exp_perf);
        chk("abort_flush_cnt_lit", 1, fc[1], exp_perf);
        chk("abort_stall_cnt_lit", 0, sc[0], exp_perf);

        repeat (3) cyc(inval(mk(K_NOP, 0, 0, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
